// File: rtl/btn_debounce_pulse_if.sv
// Purpose: button-conditioner signal bundle (raw button in, clean level/strobes/state out).
// Latency: none, wires only.
// Backpressure: none; the strobes are fire-and-forget single-cycle enables.
interface btn_debounce_pulse_if;
    logic       btn_in;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic [1:0] state_dbg;

    // Consumer side: drives the raw button, observes the conditioned outputs.
    modport master (
        output btn_in,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  state_dbg
    );

    // Debouncer side.
    modport slave (
        input  btn_in,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output state_dbg
    );
endinterface

// File: rtl/btn_debounce_pulse.sv
// Purpose: synchronise and debounce a raw pushbutton; clean level plus one-cycle press/release strobes.
// Latency: DEBOUNCE_CYCLES+3 clk edges from first stable input sample to level/strobe change.
// Backpressure: none; strobes are single-cycle and cannot be stalled by the consumer.
module btn_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic               clk,
    input  logic               reset,
    btn_debounce_pulse_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b10,
        RELEASE_WAIT = 2'b11
    } state_t;

    // Terminal count: the last of DEBOUNCE_CYCLES consecutive stable samples.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             btn_sync;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.btn_in;
            s2 <= s1;
        end
    end

    assign btn_sync = s2;

    // Debounce FSM: the counter qualifies a new level; any contrary sample falls back to the stable state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state)
                IDLE: begin
                    level_q <= 1'b0;
                    if (btn_sync) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    level_q <= 1'b0;
                    if (!btn_sync) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= HELD;
                        cnt     <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    level_q <= 1'b1;
                    if (!btn_sync) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    level_q <= 1'b1;
                    if (btn_sync) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.btn_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.state_dbg     = state;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Purpose: directed check of btn_debounce_pulse with DEBOUNCE_CYCLES=4, CNT_W=3.
// Latency: expected press/release 7 edges after the first stable input sample.
// Backpressure: n/a.
module tb_btn_debounce_pulse;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    btn_debounce_pulse_if bif ();

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    // Expected {btn_level, press_pulse, release_pulse, state_dbg}.
    localparam logic [4:0] E_IDLE  = 5'b000_00;
    localparam logic [4:0] E_IDLER = 5'b001_00;
    localparam logic [4:0] E_PW    = 5'b000_01;
    localparam logic [4:0] E_HELDP = 5'b110_10;
    localparam logic [4:0] E_HELD  = 5'b100_10;
    localparam logic [4:0] E_RW    = 5'b100_11;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int edge_no, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {bif.btn_level, bif.press_pulse, bif.release_pulse, bif.state_dbg};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s edge %0d: observed %b required %b", tag, edge_no, obs, exp);
        end
    endtask

    // Clean press from IDLE: sync 2 edges, PRESS_WAIT for 4, qualified on edge 7.
    task automatic seq_press(input string tag, input int n);
        logic [4:0] e;
        bif.btn_in = 1'b1;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (i <= 2)      e = E_IDLE;
            else if (i <= 6) e = E_PW;
            else if (i == 7) e = E_HELDP;
            else             e = E_HELD;
            check(tag, i, e);
        end
    endtask

    // Clean release from HELD, mirror image of the press.
    task automatic seq_release(input string tag, input int n);
        logic [4:0] e;
        bif.btn_in = 1'b0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (i <= 2)      e = E_HELD;
            else if (i <= 6) e = E_RW;
            else if (i == 7) e = E_IDLER;
            else             e = E_IDLE;
            check(tag, i, e);
        end
    endtask

    initial begin
        logic       b3  [14];
        logic [4:0] x3  [14];
        logic       b4  [10];
        logic [4:0] x4  [10];
        logic       b5  [13];
        logic [4:0] x5  [13];

        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        bif.btn_in = 1'b1;

        // 1: reset held with button high, then qualification from deassert.
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("t1_reset", i, E_IDLE);
        end
        reset = 1'b0;
        seq_press("t1_press", 8);
        seq_release("t1_release", 8);

        // 2: clean press held 20 cycles, then release.
        seq_press("t2_press", 20);
        seq_release("t2_release", 10);

        // 3: bouncy press 1,1,1,0,1,0,1 then steady 1 (FSM sees input two edges late).
        b3 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        x3 = '{E_IDLE, E_IDLE, E_PW, E_PW, E_PW, E_IDLE, E_PW,
               E_IDLE, E_PW, E_PW, E_PW, E_PW, E_HELDP, E_HELD};
        for (int i = 0; i < 14; i++) begin
            bif.btn_in = b3[i];
            tick();
            check("t3_bounce_press", i + 1, x3[i]);
        end
        seq_release("t3_release", 10);

        // 4: 3-cycle glitch never qualifies.
        b4 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        x4 = '{E_IDLE, E_IDLE, E_PW, E_PW, E_PW,
               E_IDLE, E_IDLE, E_IDLE, E_IDLE, E_IDLE};
        for (int i = 0; i < 10; i++) begin
            bif.btn_in = b4[i];
            tick();
            check("t4_glitch", i + 1, x4[i]);
        end

        // 5: bouncy release 0,1,0,0,1 then steady 0 from HELD.
        seq_press("t5_press", 10);
        b5 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        x5 = '{E_HELD, E_HELD, E_RW, E_HELD, E_RW, E_RW, E_HELD,
               E_RW, E_RW, E_RW, E_RW, E_IDLER, E_IDLE};
        for (int i = 0; i < 13; i++) begin
            bif.btn_in = b5[i];
            tick();
            check("t5_bounce_release", i + 1, x5[i]);
        end

        // 6a: reset while HELD with the button still down.
        seq_press("t6_press", 10);
        reset = 1'b1;
        tick();
        check("t6_reset_held", 1, E_IDLE);
        reset = 1'b0;
        seq_press("t6_repress_held", 10);
        seq_release("t6_release", 10);

        // 6b: reset while PRESS_WAIT.
        seq_press("t6_pw_entry", 4);
        reset = 1'b1;
        tick();
        check("t6_reset_pw", 1, E_IDLE);
        reset = 1'b0;
        seq_press("t6_repress_pw", 10);
        seq_release("t6_release_pw", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
